// File: rtl/sdram_to_usb_writer_pkg.sv
// Shared FX2 / Wishbone constants for the SDRAM<->USB bridges.
// State codes, endpoint addresses and byte-select patterns.
package sdram_to_usb_writer_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WB_REQ     = 3'd1;
  localparam logic [2:0] ST_WB_WAIT    = 3'd2;
  localparam logic [2:0] ST_FIFO_WAIT  = 3'd3;
  localparam logic [2:0] ST_WRITE_DATA = 3'd4;
  localparam logic [2:0] ST_PKT_END    = 3'd5;
  localparam logic [2:0] ST_DONE       = 3'd6;

  localparam logic [1:0] FX2_EP2 = 2'b00;
  localparam logic [1:0] FX2_EP6 = 2'b10;

  localparam logic [3:0] WB_SEL_NONE = 4'b0000;
  localparam logic [3:0] WB_SEL_LO16 = 4'b0011;

  typedef logic [15:0] word_t;

endpackage

// File: rtl/sdram_to_usb_writer_if.sv
// Wishbone classic single-read bus bundle.
// Master drives the request, slave returns data/ack/stall.
interface sdram_to_usb_writer_if;

  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [3:0]  sel_o;
  logic [31:0] addr_o;
  logic [31:0] data_i;
  logic        ack_i;
  logic        stall_i;

  modport master (
    output cyc_o, stb_o, we_o, sel_o, addr_o,
    input  data_i, ack_i, stall_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, sel_o, addr_o,
    output data_i, ack_i, stall_i
  );

endinterface

// File: rtl/wb_read_master.sv
// Wishbone single-word read handshake.
// Bus outputs decode from the caller's registered phase flags.
module wb_read_master
  import sdram_to_usb_writer_pkg::*;
(
  input  logic        CLKOUT,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        i_wait,
  input  logic [31:0] i_addr,
  sdram_to_usb_writer_if.master wb,
  output logic        o_issued,
  output logic        o_got,
  output word_t       o_data
);

  word_t r_data;
  logic  w_live;

  assign w_live     = i_req | i_wait;
  assign wb.cyc_o   = w_live;
  assign wb.stb_o   = i_req;
  assign wb.we_o    = 1'b0;
  assign wb.sel_o   = w_live ? WB_SEL_LO16 : WB_SEL_NONE;
  assign wb.addr_o  = w_live ? i_addr : 32'h0;

  // an ack on the accepting edge counts as this word's data
  assign o_issued = i_req & ~wb.stall_i;
  assign o_got    = (o_issued | i_wait) & wb.ack_i;
  assign o_data   = r_data;

  // capture the low half-word of an accepted read
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n)
      r_data <= '0;
    else if (o_got)
      r_data <= wb.data_i[15:0];
  end

endmodule

// File: rtl/sdram_to_usb_writer.sv
// Streams NUM_TO_WRITE words from Wishbone memory to the FX2 EP6 FIFO.
// One read, one FIFO write per word, then a short-packet commit.
module sdram_to_usb_writer
  import sdram_to_usb_writer_pkg::*;
#(
  parameter int unsigned NUM_TO_WRITE = 118,
  parameter logic [31:0] BASE_ADDR    = 32'h0
) (
  input  logic        CLKOUT,
  input  logic        rst_n,
  input  logic        start,
  input  logic        FLAGB,
  output logic        SLWR,
  output logic        SLRD,
  output logic        SLOE,
  output logic        PKTEND,
  output logic        IFCLK,
  output logic [1:0]  FIFOADR,
  inout  wire  [15:0] FDATA,
  sdram_to_usb_writer_if.master wb,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] LAST = 16'(NUM_TO_WRITE - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [15:0] r_cnt;
  logic        r_pkt_fire;
  logic        w_issued;
  logic        w_got;
  word_t       w_data;
  logic [31:0] w_addr;
  logic        w_wr;

  assign w_addr = BASE_ADDR + {16'h0, r_cnt};

  wb_read_master u_rd (
    .CLKOUT   (CLKOUT),
    .rst_n    (rst_n),
    .i_req    (r_state == ST_WB_REQ),
    .i_wait   (r_state == ST_WB_WAIT),
    .i_addr   (w_addr),
    .wb       (wb),
    .o_issued (w_issued),
    .o_got    (w_got),
    .o_data   (w_data)
  );

  // next-state selection
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:
        if (start) w_next = ST_WB_REQ;
      ST_WB_REQ:
        if (w_got)         w_next = ST_FIFO_WAIT;
        else if (w_issued) w_next = ST_WB_WAIT;
      ST_WB_WAIT:
        if (w_got) w_next = ST_FIFO_WAIT;
      ST_FIFO_WAIT:
        if (FLAGB) w_next = ST_WRITE_DATA;
      ST_WRITE_DATA:
        w_next = (r_cnt == LAST) ? ST_PKT_END
                                 : ST_WB_REQ;
      ST_PKT_END:
        if (r_pkt_fire) w_next = ST_DONE;
      ST_DONE:
        w_next = ST_IDLE;
      default:
        w_next = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // word counter: cleared on start, bumped per FIFO write
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (r_state == ST_IDLE && start)
      r_cnt <= '0;
    else if (r_state == ST_WRITE_DATA)
      r_cnt <= r_cnt + 16'd1;
  end

  // registered PKTEND request once FLAGB shows space
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n)
      r_pkt_fire <= 1'b0;
    else
      r_pkt_fire <= (r_state == ST_PKT_END) &
                    ~r_pkt_fire & FLAGB;
  end

  assign w_wr    = (r_state == ST_WRITE_DATA);
  assign SLWR    = ~w_wr;
  assign PKTEND  = ~((r_state == ST_PKT_END) & r_pkt_fire);
  assign SLRD    = 1'b1;
  assign SLOE    = 1'b1;
  assign IFCLK   = ~CLKOUT;
  assign FIFOADR = FX2_EP6;
  assign FDATA   = w_wr ? w_data : 16'hzzzz;
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);

endmodule
